// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state, opcode and control-field encodings for the multi-cycle CPU
package cpu_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_J};
  endfunction
endpackage

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main sequencing FSM of the multi-cycle CPU with memory ready stalls,
// illegal-opcode flag and retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic [1:0]       pc_src_o,
  output logic             i_or_d_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);
  state_t     state;
  logic [5:0] op_q;
  logic       retire;
  assign retire = (state inside {S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP}) ||
                  (state == S_MEM_WR && mem_ready_i);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      op_q      <= '0;
      retired_o <= '0;
    end else begin
      if (state == S_DECODE) op_q <= instr_op_i;
      if (retire) retired_o <= retired_o + CNT_W'(1);
      case (state)
        S_IDLE:     state <= S_FETCH;
        S_FETCH:    state <= mem_ready_i ? S_DECODE : S_FETCH;
        S_DECODE:
          case (instr_op_i)
            OP_RTYPE:      state <= S_R_EXEC;
            OP_LW, OP_SW:  state <= S_MEM_ADDR;
            OP_ADDI, OP_SLTI: state <= S_I_EXEC;
            OP_BEQ:        state <= S_BRANCH;
            OP_J:          state <= S_JUMP;
            default:       state <= S_FETCH;
          endcase
        S_MEM_ADDR: state <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   state <= mem_ready_i ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   state <= mem_ready_i ? S_FETCH : S_MEM_WR;
        S_R_EXEC:   state <= S_R_WB;
        S_I_EXEC:   state <= S_I_WB;
        default:    state <= S_FETCH;
      endcase
    end
  end
  // Moore decode; only the fetch-side loads also wait on mem_ready_i
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_src_o        = PC_ALU;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    illegal_o       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        illegal_o   = !legal_op(instr_op_i);
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (op_q == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      S_I_WB:   reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PC_ALUOUT;
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_JUMP;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle checks of control outputs and retire counter,
// with a second 4-bit-counter instance for wraparound.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_i = 1'b0, rdy = 1'b0;
  logic [5:0] op = 6'h00;
  logic pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, ill;
  logic [1:0] ps, asb;
  logic [2:0] aop;
  logic [31:0] ret;
  logic b_pw, b_pwc, b_iod, b_mr, b_mw, b_irw, b_rw, b_rd, b_m2r, b_asa, b_ill;
  logic [1:0] b_ps, b_asb;
  logic [2:0] b_aop;
  logic [3:0] b_ret;
  int checks = 0, errors = 0;
  logic [17:0] ctrl;
  assign ctrl = {pw, pwc, ps, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, ill};
  // fields: pw pwc ps iod mr mw irw rw rd m2r asa asb aop ill
  localparam logic [17:0] C_IDLE = 18'b0;
  localparam logic [17:0] C_FRDY = {1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [17:0] C_FWT  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0};
  localparam logic [17:0] C_DEC  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 1'b0};
  localparam logic [17:0] C_DILL = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 1'b1};
  localparam logic [17:0] C_MA   = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0};
  localparam logic [17:0] C_MRD  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] C_MWB  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] C_MWR  = {1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] C_REX  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0};
  localparam logic [17:0] C_RWB  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] C_IADD = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0};
  localparam logic [17:0] C_ISLT = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b011, 1'b0};
  localparam logic [17:0] C_IWB  = {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};
  localparam logic [17:0] C_BR   = {1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0};
  localparam logic [17:0] C_JMP  = {1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0};

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(op), .mem_ready_i(rdy),
    .pc_write_o(pw), .pc_write_cond_o(pwc), .pc_src_o(ps), .i_or_d_o(iod),
    .mem_read_o(mr), .mem_write_o(mw), .ir_write_o(irw), .reg_write_o(rw),
    .reg_dst_o(rd), .mem_to_reg_o(m2r), .alu_src_a_o(asa), .alu_src_b_o(asb),
    .alu_op_o(aop), .illegal_o(ill), .retired_o(ret)
  );
  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst_i), .instr_op_i(op), .mem_ready_i(rdy),
    .pc_write_o(b_pw), .pc_write_cond_o(b_pwc), .pc_src_o(b_ps), .i_or_d_o(b_iod),
    .mem_read_o(b_mr), .mem_write_o(b_mw), .ir_write_o(b_irw), .reg_write_o(b_rw),
    .reg_dst_o(b_rd), .mem_to_reg_o(b_m2r), .alu_src_a_o(b_asa), .alu_src_b_o(b_asb),
    .alu_op_o(b_aop), .illegal_o(b_ill), .retired_o(b_ret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [5:0] o, input logic [17:0] e);
    @(negedge clk);
    rdy = r;
    op = o;
    #1;
    check(tag, 32'(ctrl), 32'(e));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("reset_ret", ret, 32'd0);
    rst_i = 1'b1;
    #1;
    check("idle", 32'(ctrl), 32'(C_IDLE));
    // R-type
    cyc("r_fetch", 1'b1, 6'h00, C_FRDY);
    cyc("r_dec", 1'b1, 6'h00, C_DEC);
    cyc("r_exec", 1'b1, 6'h3F, C_REX);
    cyc("r_wb", 1'b1, 6'h3F, C_RWB);
    check("r_ret_before", ret, 32'd0);
    cyc("r_next_fetch", 1'b1, 6'h23, C_FRDY);
    check("r_ret_after", ret, 32'd1);
    // lw with two MEM_RD wait states; opcode changes after DECODE are ignored
    cyc("lw_dec", 1'b0, 6'h23, C_DEC);
    cyc("lw_ma", 1'b1, 6'h2B, C_MA);
    cyc("lw_rd_w1", 1'b0, 6'h2B, C_MRD);
    cyc("lw_rd_w2", 1'b0, 6'h2B, C_MRD);
    cyc("lw_rd", 1'b1, 6'h2B, C_MRD);
    cyc("lw_wb", 1'b0, 6'h2B, C_MWB);
    check("lw_ret_before", ret, 32'd1);
    cyc("beq_fetch", 1'b1, 6'h04, C_FRDY);
    check("lw_ret_after", ret, 32'd2);
    cyc("beq_dec", 1'b1, 6'h04, C_DEC);
    cyc("beq_br", 1'b0, 6'h00, C_BR);
    cyc("ill_fetch", 1'b1, 6'h3F, C_FRDY);
    check("beq_ret", ret, 32'd3);
    cyc("ill_dec", 1'b1, 6'h3F, C_DILL);
    cyc("ill_back_fetch_wait", 1'b0, 6'h3F, C_FWT);
    check("ill_ret", ret, 32'd3);
    cyc("addi_fetch", 1'b1, 6'h08, C_FRDY);
    cyc("addi_dec", 1'b1, 6'h08, C_DEC);
    cyc("addi_exec", 1'b1, 6'h0A, C_IADD);
    cyc("addi_wb", 1'b1, 6'h0A, C_IWB);
    cyc("slti_fetch", 1'b1, 6'h0A, C_FRDY);
    cyc("slti_dec", 1'b1, 6'h0A, C_DEC);
    cyc("slti_exec", 1'b1, 6'h08, C_ISLT);
    cyc("slti_wb", 1'b1, 6'h08, C_IWB);
    cyc("sw_fetch", 1'b1, 6'h2B, C_FRDY);
    check("slti_ret", ret, 32'd5);
    cyc("sw_dec", 1'b1, 6'h2B, C_DEC);
    cyc("sw_ma", 1'b1, 6'h23, C_MA);
    cyc("sw_wr_w1", 1'b0, 6'h23, C_MWR);
    cyc("sw_wr_w2", 1'b0, 6'h23, C_MWR);
    rst_i = 1'b0;
    #1;
    check("rst_mw", 32'(mw), 32'd0);
    check("rst_ctrl", 32'(ctrl), 32'(C_IDLE));
    check("rst_ret", ret, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    rdy = 1'b1;
    #1;
    check("idle2", 32'(ctrl), 32'(C_IDLE));
    for (int i = 0; i < 16; i++) begin
      cyc("j_fetch", 1'b1, 6'h02, C_FRDY);
      if (i == 15) check("j_wrap_pre", 32'(b_ret), 32'd15);
      cyc("j_dec", 1'b1, 6'h02, C_DEC);
      cyc("j_jump", 1'b1, 6'h02, C_JMP);
    end
    cyc("j_end_fetch", 1'b1, 6'h02, C_FRDY);
    check("j_ret32", ret, 32'd16);
    check("j_ret4_wrap", 32'(b_ret), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control state machine for the multi-cycle version of the MIPS-subset CPU. It sequences the shared datapath (PC, unified memory, instruction register, register file, ALU, ALUOut) one micro-step per cycle. It decodes `instr_op_i` from the instruction register and stalls on memory wait states through a ready handshake. It also flags unsupported opcodes and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk_i`  in  1  clock, all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `instr_op_i`  in  6  opcode field (IR[31:26]); sampled only in DECODE.
- `mem_ready_i`  in  1  memory completes the current access this cycle.
- `pc_write_o`  out  1  unconditional PC load.
- `pc_write_cond_o`  out  1  PC load gated externally by ALU zero.
- `pc_src_o`  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- `i_or_d_o`  out  1  memory address: 0 PC, 1 ALUOut.
- `mem_read_o`, `mem_write_o`  out  1 each  memory strobes.
- `ir_write_o`  out  1  instruction register load.
- `reg_write_o`, `reg_dst_o`, `mem_to_reg_o`  out  1 each  register-file write enable, rd/rt select, memory/ALU writeback select.
- `alu_src_a_o`  out  1  ALU A input: 0 PC, 1 rs.
- `alu_src_b_o`  out  2  ALU B input: 00 rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- `alu_op_o`  out  3  ALU operation: 000 ADD, 001 SUB, 010 FUNCT (defer to ALU_Ctrl), 011 SLT.
- `illegal_o`  out  1  one-cycle pulse on an unsupported opcode.
- `retired_o`  out  `CNT_W`  count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- IDLE is entered on reset only. Every output is 0 in IDLE. IDLE moves to FETCH unconditionally.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - While `mem_ready_i`=0 it stays in FETCH with ir_write=0 and pc_write=0.
  - When `mem_ready_i`=1 it drives ir_write=1 and pc_write=1 in that same cycle, then moves to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=ADD, so ALUOut captures the branch target.
  - Dispatches on the opcode: 0x00 to R_EXEC; 0x23 (lw) and 0x2B (sw) to MEM_ADDR; 0x08 (addi) and 0x0A (slti) to I_EXEC; 0x04 (beq) to BRANCH; 0x02 (j) to JUMP.
  - Any other opcode pulses illegal_o, goes to FETCH, and does not retire.
- MEM_ADDR drives alu_src_a=1, alu_src_b=10, alu_op=ADD. It moves to MEM_RD for lw and MEM_WR for sw, using the opcode latched in DECODE.
- MEM_RD drives mem_read=1, i_or_d=1. It waits for `mem_ready_i`, then moves to MEM_WB.
- MEM_WB drives reg_write=1, reg_dst=0, mem_to_reg=1, then moves to FETCH.
- MEM_WR drives mem_write=1, i_or_d=1. It waits for `mem_ready_i`, then moves to FETCH.
- R_EXEC drives alu_src_a=1, alu_src_b=00, alu_op=FUNCT. R_WB drives reg_write=1, reg_dst=1, mem_to_reg=0.
- I_EXEC drives alu_src_a=1, alu_src_b=10, with alu_op=ADD for addi and SLT for slti. I_WB drives reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH drives alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_src=01.
- JUMP drives pc_write=1, pc_src=10.
- Outputs not listed for a state are 0.
- `retired_o` increments by 1 on the exit edge of MEM_WB, MEM_WR (when ready), R_WB, I_WB, BRANCH and JUMP. It wraps modulo 2^`CNT_W`.

## Timing
- Outputs are Moore functions of the state. The exceptions are `ir_write_o` and FETCH `pc_write_o`, which are additionally ANDed with `mem_ready_i`.
- Cycles per instruction with zero wait states: beq/j 3, R-type/addi/slti/sw 4, lw 5. Each cycle `mem_ready_i` is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- The cycle after reset deassertion is IDLE. FETCH is asserted in the second cycle.
- Asserting reset at any point, including mid-stall, forces IDLE, zeroes all outputs, and clears `retired_o` immediately. No write strobe may remain high after reset assertion.
- `mem_ready_i` outside FETCH/MEM_RD/MEM_WR is ignored.
- An opcode change outside DECODE has no effect.

## Structure
- Shared package `cpu_pkg`:
  - state enum (4-bit);
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ, OP_J);
  - alu_op codes;
  - pc_src and alu_src_b encodings.
- Single module, no sub-modules. It contains a state register, a latched-opcode register, the output decode and the retire counter.

## Test plan
- Reset release, `mem_ready_i`=1, opcode 0x00 → states IDLE, FETCH, DECODE, R_EXEC, R_WB, FETCH. R_WB shows reg_write=1 and reg_dst=1. `retired_o` goes 0→1.
- lw (0x23) with `mem_ready_i` low for 2 cycles in MEM_RD → 7 cycles FETCH-to-FETCH. mem_read=1 and i_or_d=1 hold throughout the stall. MEM_WB shows mem_to_reg=1.
- beq (0x04) → BRANCH cycle shows pc_write_cond=1, pc_src=01, alu_op=001. Next state is FETCH, 3 cycles total.
- Opcode 0x3F → illegal_o high for exactly 1 cycle, return to FETCH, `retired_o` unchanged.
- Reset asserted during a MEM_WR stall → mem_write_o drops in the same cycle, state is IDLE, `retired_o`=0.
- `CNT_W`=4, 16 back-to-back j (0x02) instructions → `retired_o` wraps to 0. Each j takes 3 cycles with pc_src=10.
